aes128_enc_iter: RTL and testbench

//  Iterative AES-128 encryption core (FIPS-197), generalised successor to the single-round AES stage.

---
 rtl/aes128_enc_iter.sv | 232 +++++++++++++++++++++++
 tb/tb_aes128_enc_iter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: SubBytes is spread over 16/SBOX_LANES cycles, then one
// cycle performs ShiftRows/MixColumns/AddRoundKey with the next round key expanded on the fly.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (m[i] ? t : 8'h00);
            t = xtime(t);
        end
        return p;
    endfunction

    // Inverse computed as x^254, which conveniently maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign y = affine(ginv(a));
endmodule

module aes128_enc_iter #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);
    // Element 0 is bits [127:120], i.e. byte 0 of the column-major state
    typedef logic [0:15][7:0] blk_t;
    typedef enum logic [1:0] {IDLE, SUB, MIXKEY, DONE} fsm_t;

    localparam int         NLANE     = 16 / SBOX_LANES;
    localparam logic [3:0] LAST_LANE = 4'(NLANE - 1);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
        $error("aes128_enc_iter: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_t         fsm_r, fsm_nxt_s;
    blk_t         st_r, rk_r, st_sub_s, nk_s, mix_s;
    logic [3:0]   rnd_r, lane_cnt_r;
    logic [127:0] out_block_r;
    logic         in_ready_r, out_valid_r, busy_r;
    logic [7:0]   sb_out_s [SBOX_LANES];
    logic [3:0]   sb_idx_s [SBOX_LANES];
    logic [7:0]   ks_out_s [4];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic blk_t shift_rows(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[c*4+r] = s[((c + r) % 4)*4 + r];
            end
        end
        return o;
    endfunction

    function automatic blk_t mix_columns(input blk_t s);
        blk_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[c*4];
            a1 = s[c*4+1];
            a2 = s[c*4+2];
            a3 = s[c*4+3];
            o[c*4]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[c*4+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[c*4+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[c*4+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
        assign sb_idx_s[j] = 4'(lane_cnt_r * 4'(SBOX_LANES) + 4'(j));
        aes_sbox u_sbox (.a(st_r[sb_idx_s[j]]), .y(sb_out_s[j]));
    end

    // Key-schedule S-boxes take RotWord of the last key word directly
    for (genvar k = 0; k < 4; k++) begin : g_ks
        aes_sbox u_ks_sbox (.a(rk_r[12 + ((k + 1) % 4)]), .y(ks_out_s[k]));
    end

    // Merge this cycle's substituted lane into the state
    always_comb begin
        st_sub_s = st_r;
        for (int j = 0; j < SBOX_LANES; j++) begin
            st_sub_s[sb_idx_s[j]] = sb_out_s[j];
        end
    end

    // Next round key and the round result (final round omits MixColumns)
    always_comb begin
        blk_t nk_v;
        for (int b = 0; b < 4; b++) begin
            nk_v[b] = rk_r[b] ^ ks_out_s[b];
        end
        nk_v[0] = nk_v[0] ^ rcon(rnd_r);
        for (int w = 1; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                nk_v[w*4+b] = rk_r[w*4+b] ^ nk_v[(w-1)*4+b];
            end
        end
        nk_s = nk_v;
        if (rnd_r == 4'd10) begin
            mix_s = shift_rows(st_r) ^ nk_v;
        end else begin
            mix_s = mix_columns(shift_rows(st_r)) ^ nk_v;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            IDLE:    if (in_valid && in_ready_r) fsm_nxt_s = SUB;    else fsm_nxt_s = IDLE;
            SUB:     if (lane_cnt_r == LAST_LANE) fsm_nxt_s = MIXKEY; else fsm_nxt_s = SUB;
            MIXKEY:  if (rnd_r == 4'd10)          fsm_nxt_s = DONE;   else fsm_nxt_s = SUB;
            DONE:    if (out_ready)               fsm_nxt_s = IDLE;   else fsm_nxt_s = DONE;
            default: fsm_nxt_s = IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_nxt_s;
            in_ready_r  <= (fsm_nxt_s == IDLE);
            out_valid_r <= (fsm_nxt_s == DONE);
            busy_r      <= (fsm_nxt_s != IDLE);
        end
    end

    // Datapath: state, round key, counters and the held ciphertext
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r        <= 128'd0;
            rk_r        <= 128'd0;
            rnd_r       <= 4'd0;
            lane_cnt_r  <= 4'd0;
            out_block_r <= 128'd0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        st_r       <= in_block ^ in_key;
                        rk_r       <= in_key;
                        rnd_r      <= 4'd1;
                        lane_cnt_r <= 4'd0;
                    end
                end
                SUB: begin
                    st_r       <= st_sub_s;
                    lane_cnt_r <= lane_cnt_r + 4'd1;
                end
                MIXKEY: begin
                    st_r <= mix_s;
                    rk_r <= nk_s;
                    if (rnd_r == 4'd10) begin
                        out_block_r <= mix_s;
                    end else begin
                        rnd_r      <= rnd_r + 4'd1;
                        lane_cnt_r <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_block = out_block_r;
    assign busy      = busy_r;
endmodule

// File: tb/tb_aes128_enc_iter.sv
// Scoreboarded bench for aes128_enc_iter: three instances (4, 1 and 16 S-box lanes) run the
// same directed and random sequences against a table-driven AES reference model.

module tb_aes128_enc_iter;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] blk;
        int           acc;
    } sb_ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int gexp [256];
    int glog [256];
    logic [7:0] sb_tab [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return 8'(gexp[(glog[a] + glog[b]) % 255]);
    endfunction

    // Textbook AES-128: full key schedule first, then ten rounds
    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [44][4];
        logic [7:0] tmp [4];
        logic [7:0] base [4];
        logic [7:0] rc, a;
        logic [127:0] res;
        base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 16; i++) begin
            w[i/4][i%4] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int k = 0; k < 4; k++) tmp[k] = w[i-1][k];
            if (i % 4 == 0) begin
                for (int k = 0; k < 4; k++) tmp[k] = sb_tab[w[i-1][(k+1)%4]];
                tmp[0] = tmp[0] ^ rc;
                rc = xt(rc);
            end
            for (int k = 0; k < 4; k++) w[i][k] = w[i-4][k] ^ tmp[k];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) begin
                    if (r < 10) begin
                        a = 8'h00;
                        for (int k = 0; k < 4; k++) a = a ^ gm(base[(k-row+4)%4], t[4*c+k]);
                        s[4*c+row] = a;
                    end else begin
                        s[4*c+row] = t[4*c+row];
                    end
                    s[4*c+row] = s[4*c+row] ^ w[4*r+c][row];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LN  = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        localparam int LAT = 10 * (16 / LN + 1);

        logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
        logic [127:0] in_block, in_key, out_block;
        sb_ent_t      q[$];
        logic         prev_v = 1'b0;
        int           last_hs = 0;

        aes128_enc_iter #(.SBOX_LANES(LN)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_key(in_key),
            .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
        );

        task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
            n_checks = n_checks + 1;
            if (act !== want) begin
                n_fail = n_fail + 1;
                $display("FAIL %s [lanes=%0d] @cyc %0d: got %h, expected %h", nm, LN, cyc, act, want);
            end
        endtask

        task automatic send(input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] want, input bit hold, output int acc);
            sb_ent_t e;
            int n;
            in_block = pt;
            in_key   = key;
            in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("accept_timeout", 128'(n >= 500), 128'd0);
            acc   = cyc + 1;
            e.blk = want;
            e.acc = acc;
            q.push_back(e);
            @(posedge clk);
            #1;
            if (!hold) begin
                in_valid = 1'b0;
                in_block = {$urandom, $urandom, $urandom, $urandom};
                in_key   = {$urandom, $urandom, $urandom, $urandom};
            end
        endtask

        task automatic wait_valid();
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("valid_timeout", 128'(n >= 500), 128'd0);
        endtask

        task automatic wait_hs();
            int n;
            n = 0;
            @(negedge clk);
            while (!(out_valid && out_ready) && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("handshake_timeout", 128'(n >= 500), 128'd0);
            @(posedge clk);
            #1;
        endtask

        // Monitor: latency on each rising out_valid, ciphertext on each output handshake
        always @(negedge clk) begin
            if (out_valid && !prev_v) begin
                chk("out_expected", 128'(q.size() != 0), 128'd1);
                if (q.size() != 0) chk("latency", 128'(cyc - q[0].acc), 128'(LAT));
            end
            if (out_valid && out_ready && q.size() != 0) begin
                chk("ciphertext", out_block, q[0].blk);
                last_hs <= cyc + 1;
                void'(q.pop_front());
            end
            prev_v <= out_valid;
        end

        initial begin
            int acc_a, acc_b, hs_a;
            logic [127:0] pt, key;
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            in_block = 128'd0; in_key = 128'd0;
            repeat (3) @(posedge clk);
            #1;
            chk("rst_out_valid", 128'(out_valid), 128'd0);
            chk("rst_in_ready", 128'(in_ready), 128'd1);
            chk("rst_busy", 128'(busy), 128'd0);
            chk("rst_out_block", out_block, 128'd0);
            rst = 1'b0;
            @(posedge clk);
            #1;

            out_ready = 1'b1;
            send(P1, K1, C1, 1'b0, acc_a);
            chk("busy_after_accept", 128'(busy), 128'd1);
            wait_hs();
            send(P2, K2, C2, 1'b0, acc_a);
            wait_hs();

            out_ready = 1'b0;
            send(P1, K1, C1, 1'b0, acc_a);
            wait_valid();
            for (int i = 0; i < 25; i++) begin
                if (i != 0) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                end
                chk("bp_block", out_block, C1);
                chk("bp_in_ready", 128'(in_ready), 128'd0);
                chk("bp_out_valid", 128'(out_valid), 128'd1);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_release_valid", 128'(out_valid), 128'd0);
            chk("bp_release_ready", 128'(in_ready), 128'd1);

            send(P1, K1, C1, 1'b1, acc_a);
            send(P2, K2, C2, 1'b0, acc_b);
            hs_a = last_hs;
            chk("b2b_accept_gap", 128'(acc_b - hs_a), 128'd1);
            wait_hs();

            send(P1, K1, C1, 1'b0, acc_a);
            repeat (4 * (16 / LN + 1)) @(posedge clk);
            #1;
            chk("r5_busy", 128'(busy), 128'd1);
            rst = 1'b1;
            #1;
            chk("arst_out_valid", 128'(out_valid), 128'd0);
            chk("arst_in_ready", 128'(in_ready), 128'd1);
            chk("arst_busy", 128'(busy), 128'd0);
            chk("arst_out_block", out_block, 128'd0);
            q.delete();
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            #1;
            send(P1, K1, C1, 1'b0, acc_a);
            wait_hs();

            for (int i = 0; i < 6; i++) begin
                pt  = {$urandom, $urandom, $urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
                out_ready = 1'($urandom_range(0, 1));
                send(pt, key, model_enc(pt, key), 1'b0, acc_a);
                repeat ($urandom_range(0, LAT - 2)) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b0;
                wait_valid();
                repeat ($urandom_range(0, 3)) @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                wait_hs();
            end
            chk("queue_drained", 128'(q.size()), 128'd0);
            done_cnt = done_cnt + 1;
        end
    end

    initial begin
        int x;
        logic [7:0] b, s, cc;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x ^ int'(xt(8'(x)));
        end
        gexp[255] = 1;
        glog[0] = 0;
        cc = 8'h63;
        for (int v = 0; v < 256; v++) begin
            b = (v == 0) ? 8'h00 : 8'(gexp[(255 - glog[v]) % 255]);
            for (int k = 0; k < 8; k++)
                s[k] = b[k] ^ b[(k+4)%8] ^ b[(k+5)%8] ^ b[(k+6)%8] ^ b[(k+7)%8] ^ cc[k];
            sb_tab[v] = s;
        end
        while (done_cnt < 3 && cyc < 60000) @(posedge clk);
        if (done_cnt < 3) begin
            n_checks = n_checks + 1;
            n_fail = n_fail + 1;
            $display("FAIL watchdog: %0d of 3 instances finished, expected 3", done_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
